// File: rtl/bus_master_if.sv
// Bus-master front end: takes one burst command, requests the bus, issues beats while granted, then releases for one cycle.
// Optional grant-wait timeout with err output when BUS_MASTER_TIMEOUT_EN is defined.
module bus_master_if #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int LW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wr_data,
  output logic          wr_data_pop,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic          M_req,
  input  logic          M_grant,
  output logic          M_wr,
  output logic [AW-1:0] M_addr,
  output logic [DW-1:0] M_wdata,
  input  logic [DW-1:0] M_rdata
`ifdef BUS_MASTER_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] REL  = 2'd2;

  logic [1:0]    state;
  logic          wr_reg;
  logic [AW-1:0] addr_reg;
  logic [LW-1:0] remaining;
  logic          beat;
  logic          timeout_hit;

  assign beat        = (state == BUS) && M_grant;
  assign cmd_ready   = (state == IDLE);
  assign M_req       = (state == BUS);
  assign done        = (state == REL);
  assign M_wr        = beat && wr_reg;
  assign wr_data_pop = beat && wr_reg;
  assign M_addr      = beat ? addr_reg : '0;
  assign M_wdata     = (beat && wr_reg) ? wr_data : '0;
  // Slave data arrives the cycle after the address beat; rd_valid is the registered marker for it.
  assign rd_data     = rd_valid ? M_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= beat && !wr_reg;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_reg    <= cmd_wr;
            addr_reg  <= cmd_addr;
            remaining <= cmd_len;
            state     <= BUS;
          end
        end
        BUS: begin
          if (beat) begin
            addr_reg  <= addr_reg + {{(AW-1){1'b0}}, 1'b1};
            remaining <= remaining - {{(LW-1){1'b0}}, 1'b1};
            if (remaining == '0) state <= REL;
          end else if (timeout_hit) begin
            state <= REL;
          end
        end
        REL:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          started;

  // Only the wait for the first grant of a burst is bounded; later grant gaps are tolerated.
  assign timeout_hit = (state == BUS) && !started && !M_grant &&
                       (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      started  <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (state != BUS) begin
        wait_cnt <= '0;
        started  <= 1'b0;
      end else if (beat) begin
        wait_cnt <= '0;
        started  <= 1'b1;
      end else if (!started) begin
        wait_cnt <= wait_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  // Without the timeout build the master waits for grant indefinitely.
  assign timeout_hit = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed bursts plus randomized bursts/grant patterns
// checked cycle by cycle against a burst-level model (beat k carries addr+k and source word k).
module tb_bus_master_if;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_data_pop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       M_req;
  logic       M_grant;
  logic       M_wr;
  logic [7:0] M_addr;
  logic [7:0] M_wdata;
  logic [7:0] M_rdata;
`ifdef BUS_MASTER_TIMEOUT_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] wsrc [16];
  int widx;

  bus_master_if #(.AW(8), .DW(8), .LW(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_data_pop(wr_data_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .M_req(M_req), .M_grant(M_grant), .M_wr(M_wr),
    .M_addr(M_addr), .M_wdata(M_wdata), .M_rdata(M_rdata)
`ifdef BUS_MASTER_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one burst. gpat[c] is the grant in the c-th cycle after acceptance.
  // Entered and left just after a negedge with the DUT idle.
  task automatic run_burst(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                           input logic [63:0] gpat, input int base);
    int n = int'(len) + 1;
    int k = 0;
    int c = 0;
    logic rdpend = 1'b0;
    logic rdpend_nxt;
    logic [7:0] exp_rd = 8'h00;
    logic [7:0] exp_rd_nxt;
    logic [7:0] a_s;
    logic p_s;
    logic g;
    for (int i = 0; i < 16; i++) wsrc[i] = (base >= 0) ? 8'(base + i) : 8'($urandom);
    widx = 0;
    wr_data = wsrc[0];
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_addr = 8'($urandom); cmd_len = 4'($urandom);
    while (1) begin
      if (c >= 64) begin
        chk("burst_bound", k, n);
        break;
      end
      g = gpat[c];
      M_grant = g;
      @(negedge clk);
      a_s = M_addr;
      p_s = wr_data_pop;
`ifdef BUS_MASTER_TIMEOUT_EN
      chk("err_low", err, 0);
`endif
      chk("rd_valid", rd_valid, rdpend);
      if (rdpend) chk("rd_data", rd_data, exp_rd);
      if (k < n) begin
        chk("bus_req", M_req, 1);
        chk("bus_cmd_ready", cmd_ready, 0);
        chk("bus_done", done, 0);
        chk("m_addr", M_addr, g ? 8'(addr + k) : 8'h00);
        chk("m_wr", M_wr, g && wr);
        chk("pop", wr_data_pop, g && wr);
        chk("m_wdata", M_wdata, (g && wr) ? wsrc[k] : 8'h00);
        rdpend_nxt = g && !wr;
        exp_rd_nxt = 8'(addr + k + 8'h80);
        if (g) k++;
      end else begin
        chk("rel_done", done, 1);
        chk("rel_req", M_req, 0);
        chk("rel_wr", M_wr, 0);
        break;
      end
      rdpend = rdpend_nxt;
      exp_rd = exp_rd_nxt;
      @(posedge clk); #1;
      if (p_s) widx++;
      wr_data = wsrc[widx[3:0]];
      M_rdata = 8'(a_s + 8'h80);
      c++;
    end
    @(posedge clk); #1;
    M_grant = 1'($urandom);
    M_rdata = 8'h80;
    @(negedge clk);
    chk("after_cmd_ready", cmd_ready, 1);
    chk("after_done", done, 0);
    chk("after_req", M_req, 0);
    chk("after_rd_valid", rd_valid, 0);
    chk("after_addr", M_addr, 0);
  endtask

  initial begin
    logic [63:0] gp;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_len = 4'h0;
    wr_data = 8'h00; M_grant = 1'b1; M_rdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req", M_req, 0);
    chk("rst_wr", M_wr, 0);
    chk("rst_addr", M_addr, 0);
    chk("rst_wdata", M_wdata, 0);
    chk("rst_pop", wr_data_pop, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
`ifdef BUS_MASTER_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);

    run_burst(1'b1, 8'h10, 4'd3, ~64'h0, 8'hA0);              // write, continuous grant
    run_burst(1'b0, 8'h20, 4'd1, ~64'h0, -1);                 // read, rd_data = addr+0x80
    run_burst(1'b1, 8'h33, 4'd0, ~64'h0 << 5, -1);            // grant late by 5 cycles
    run_burst(1'b0, 8'hFE, 4'd3, ~64'h0, -1);                 // address wrap
    run_burst(1'b1, 8'h50, 4'd3, ~64'h0 & ~64'hC, -1);        // 2-cycle grant gap mid-burst
    run_burst(1'b0, 8'h00, 4'd15, ~64'h0, -1);                // longest burst
`ifndef BUS_MASTER_TIMEOUT_EN
    run_burst(1'b1, 8'h77, 4'd1, ~64'h0 << 20, -1);           // long grant wait, no timeout
`endif

    for (int t = 0; t < 10; t++) begin
      gp = {$urandom, $urandom} | {$urandom, $urandom};
      gp[63:40] = '1;
      gp[8] = 1'b1;
      run_burst(1'($urandom), 8'($urandom), 4'($urandom), gp, -1);
    end

    // Reset in the middle of a 4-beat read burst.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h40; cmd_len = 4'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0; M_grant = 1'b1;
    @(negedge clk);
    chk("rstmid_beat1", M_addr, 8'h40);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_beat2", M_addr, 8'h41);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_req", M_req, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_done", done, 0);
    chk("rstmid_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_done_later", done, 0);
    chk("rstmid_idle", cmd_ready, 1);

`ifdef BUS_MASTER_TIMEOUT_EN
    begin
      int beats = 0;
      int done_cyc = -1;
      logic err_at_done = 1'b0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h90; cmd_len = 4'd2;
      @(posedge clk); #1;
      cmd_valid = 1'b0; M_grant = 1'b0;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
        @(negedge clk);
        if (M_wr || wr_data_pop) beats++;
        if (done) begin
          done_cyc = c;
          err_at_done = err;
        end
        @(posedge clk); #1;
      end
      chk("to_done_cycle", done_cyc, 16);
      chk("to_err", err_at_done, 1);
      chk("to_beats", beats, 0);
      @(negedge clk);
      chk("to_err_clear", err, 0);
      chk("to_idle", cmd_ready, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Bus-master front end that sits directly upstream of the two-master bus arbiter.
- Accepts one burst command from a local client (timer/FIFO/counter control), raises the master request line, and waits for grant.
- Drives address/control/write-data beats on the shared bus while granted, returns read data to the client, then releases the request so the other master can win.
- Two instances per system: one on the M0 port, one on the M1 port.

Parameters:
AW, 8, bus address width
DW, 8, bus data width
LW, 4, burst length field width; beats = cmd_len+1 (1..2^LW)
TIMEOUT, 15, grant-wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  client command present
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&cmd_ready
cmd_wr  in  1  1=write burst, 0=read burst
cmd_addr  in  AW  burst start address
cmd_len  in  LW  beats minus one
wr_data  in  DW  write data, first-word-fall-through from client source
wr_data_pop  out  1  pulse: wr_data consumed this cycle
rd_data  out  DW  read data to client
rd_valid  out  1  rd_data valid this cycle
done  out  1  one-cycle pulse at burst completion
M_req  out  1  bus request to arbiter
M_grant  in  1  grant from arbiter
M_wr  out  1  bus write strobe
M_addr  out  AW  bus address
M_wdata  out  DW  bus write data
M_rdata  in  DW  slave read data, valid the cycle after the address beat

Behaviour:
- Reset values: state IDLE; cmd_ready=1; M_req=0; M_wr=0; M_addr=0; M_wdata=0; wr_data_pop=0; rd_valid=0; rd_data=0; done=0.
- States:
  - IDLE: cmd_ready=1, M_req=0. On accept, latch wr/addr/len into regs; remaining=len. Next state BUS.
  - BUS: M_req=1. A cycle with M_grant=1 is a beat:
    - M_addr=addr_reg.
    - Write burst: M_wr=1, M_wdata=wr_data, wr_data_pop=1.
    - Read burst: M_wr=0.
    - addr_reg increments mod 2^AW (0xFF wraps to 0x00); remaining decrements.
    - Beat with remaining==0 is the last beat; next state REL.
    - M_grant=0 in BUS: no beat; M_wr=0, wr_data_pop=0; burst pauses and resumes when grant returns.
  - REL: M_req=0 for exactly one cycle (lets arbiter hand over); done=1 this cycle. Next state IDLE.
- Beats are combinational from state, M_grant and regs. M_addr/M_wdata hold 0 outside beats.
- Grant present before request (arbiter default owner) means the first beat occurs in the first BUS cycle.
- Read return: registered. rd_valid=1 and rd_data=M_rdata one cycle after each read beat. The last read's rd_valid coincides with done in REL.
- Minimum latency: accept at edge 0; first beat in cycle 1 if granted; an N-beat burst with continuous grant completes (done) in cycle N+1; cmd_ready high again in cycle N+2.
- cmd_valid while busy is ignored (cmd_ready=0); the client holds it.
- Reset asserted mid-burst: next cycle IDLE, M_req=0, no done, pending rd_valid suppressed, counters cleared.

Optional Feature:
- Macro BUS_MASTER_TIMEOUT_EN.
- When defined:
  - Extra output port err (1 bit, reset 0).
  - Counter runs in BUS while no beat has yet been issued for the current burst.
  - If it reaches TIMEOUT with M_grant still 0: go to REL, pulse done with err=1 in the same cycle, no beats issued.
  - Counter clears on any beat.
- When undefined: no err port; the master waits for grant indefinitely.

Test Plan:
1. Write burst, addr 0x10, len 3, M_grant tied 1, wr_data source 0xA0.. -> beats at 0x10,0x11,0x12,0x13 with M_wdata 0xA0..0xA3 in cycles 1-4; 4 wr_data_pop pulses; done in cycle 5; M_req low in cycle 5.
2. Read burst, addr 0x20, len 1, slave model M_rdata=addr+0x80 -> rd_valid in cycles 2 and 3 with rd_data 0xA0, 0xA1; done in cycle 3.
3. Grant held 0 for 5 cycles, then 1, len 0 write -> M_req high throughout, no M_wr or pop for 5 cycles; single beat in cycle 6; done in cycle 7.
4. Wrap: addr 0xFE, len 3, read -> M_addr sequence 0xFE,0xFF,0x00,0x01.
5. Grant drops for 2 cycles mid write burst of 4 -> beats pause, no pops during gap, all 4 data words delivered in order, done after 4th beat.
6. Reset asserted after 2nd beat of 4 -> next cycle M_req=0, cmd_ready=1, no done. With BUS_MASTER_TIMEOUT_EN and grant stuck 0 -> done=1, err=1 after 15 BUS cycles, zero beats.
